// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types, opcode constants and small helpers for the tournament branch predictor.
package bpred_pkg;

    typedef enum logic [1:0] {
        PredSnt = 2'b00,
        PredWnt = 2'b01,
        PredWt  = 2'b10,
        PredSt  = 2'b11
    } prediction_t;

    // Meta fields are sized for the largest supported configuration; upper bits stay zero.
    localparam int unsigned MaxGhrBits    = 16;
    localparam int unsigned MaxRasPtrBits = 8;

    typedef struct packed {
        prediction_t                local_st;
        prediction_t                global_st;
        logic [MaxGhrBits-1:0]      ghr;
        logic [MaxRasPtrBits-1:0]   ras_ptr;
        logic [MaxRasPtrBits:0]     ras_cnt;
        logic                       chose_global;
    } bpred_meta_t;

    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    typedef struct packed {
        logic branch;
        logic jump;
        logic call;
        logic ret;
    } ctrl_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t c;
        logic  jal;
        logic  jalr;
        jal      = (inst[6:0] == OpcJal);
        jalr     = (inst[6:0] == OpcJalr);
        c.branch = (inst[6:0] == OpcBranch);
        c.jump   = jal || jalr;
        c.call   = c.jump && is_link(inst[11:7]);
        c.ret    = jalr && is_link(inst[19:15]) && (inst[19:15] != inst[11:7]);
        return c;
    endfunction

    function automatic prediction_t sat_step(input prediction_t c, input logic up);
        logic [1:0] v;
        v = c;
        if (up && v != 2'b11) begin
            v = v + 2'd1;
        end else if (!up && v != 2'b00) begin
            v = v - 2'd1;
        end
        return prediction_t'(v);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack with speculative push/pop/replace and pointer restore.
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned PTR_BITS  = $clog2(RAS_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [31:0]         push_addr,
    input  logic                restore,
    input  logic [PTR_BITS-1:0] restore_ptr,
    input  logic [PTR_BITS:0]   restore_cnt,
    output logic [31:0]         top,
    output logic [PTR_BITS-1:0] ptr,
    output logic [PTR_BITS:0]   cnt
);

    localparam logic [PTR_BITS:0] Full = (PTR_BITS + 1)'(RAS_DEPTH);

    logic [31:0]         stack_q [RAS_DEPTH];
    logic [PTR_BITS-1:0] ptr_q, ptr_d, base_ptr, wr_ptr;
    logic [PTR_BITS:0]   cnt_q, cnt_d, base_cnt;
    logic                wr_en;

    // ptr_q names the next free slot; the top of stack sits just below it.
    always_comb begin
        base_ptr = restore ? restore_ptr : ptr_q;
        base_cnt = restore ? restore_cnt : cnt_q;
        ptr_d    = base_ptr;
        cnt_d    = base_cnt;
        wr_en    = 1'b0;
        wr_ptr   = base_ptr;
        if (push && pop && base_cnt != '0) begin
            wr_en  = 1'b1;
            wr_ptr = base_ptr - 1'b1;
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = base_ptr + 1'b1;
            if (base_cnt != Full) begin
                cnt_d = base_cnt + 1'b1;
            end
        end else if (pop && base_cnt != '0) begin
            ptr_d = base_ptr - 1'b1;
            cnt_d = base_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_ptr] <= push_addr;
        end
    end

    assign top = stack_q[ptr_q - 1'b1];
    assign ptr = ptr_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament predictor: local/gshare PHTs with per-entry chooser, tagged BTB and a RAS.
module tournament_branch_predictor
    import bpred_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned GHR_BITS   = 4,
    parameter int unsigned RAS_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic        lookup_advance,
    input  logic [31:0] lookup_pc,
    input  logic [31:0] lookup_inst,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [1:0]  pred_state,
    output bpred_meta_t pred_meta,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_inst,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  bpred_meta_t upd_meta
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam int unsigned TagBits = 30 - INDEX_BITS;
    localparam int unsigned PtrBits = $clog2(RAS_DEPTH);

    prediction_t         local_pht  [Entries];
    prediction_t         global_pht [Entries];
    prediction_t         chooser    [Entries];
    logic                btb_valid  [Entries];
    logic [TagBits-1:0]  btb_tag    [Entries];
    logic [31:0]         btb_target [Entries];
    logic [GHR_BITS-1:0] ghr_q;

    logic [31:0]         ras_top;
    logic [PtrBits-1:0]  ras_ptr;
    logic [PtrBits:0]    ras_cnt;
    logic                ras_push, ras_pop, ras_restore;
    logic [31:0]         ras_addr;

    ctrl_t               lk, up;
    logic [INDEX_BITS-1:0] l_idx, l_gidx, u_idx, u_gidx;
    prediction_t         chosen;
    logic                btb_hit;
    logic                unused_meta;

    assign lk     = decode(lookup_inst);
    assign up     = decode(upd_inst);
    assign l_idx  = lookup_pc[INDEX_BITS+1:2];
    assign l_gidx = l_idx ^ INDEX_BITS'(ghr_q);
    assign u_idx  = upd_pc[INDEX_BITS+1:2];
    assign u_gidx = u_idx ^ INDEX_BITS'(upd_meta.ghr[GHR_BITS-1:0]);

    always_comb begin
        chosen      = chooser[l_idx][1] ? global_pht[l_gidx] : local_pht[l_idx];
        btb_hit     = btb_valid[l_idx] && (btb_tag[l_idx] == lookup_pc[31:INDEX_BITS+2]);
        pred_taken  = 1'b0;
        pred_target = lookup_pc + 32'd4;
        pred_state  = PredWnt;
        if (lookup_valid) begin
            if (lk.branch) begin
                pred_state = chosen;
                if (chosen[1] && btb_hit) begin
                    pred_taken  = 1'b1;
                    pred_target = btb_target[l_idx];
                end
            end else if (lk.ret && ras_cnt != '0) begin
                pred_taken  = 1'b1;
                pred_target = ras_top;
                pred_state  = PredSt;
            end else if (lk.jump && btb_hit) begin
                pred_taken  = 1'b1;
                pred_target = btb_target[l_idx];
                pred_state  = PredSt;
            end
        end
    end

    assign pred_meta = '{
        local_st:     local_pht[l_idx],
        global_st:    global_pht[l_gidx],
        ghr:          MaxGhrBits'(ghr_q),
        ras_ptr:      MaxRasPtrBits'(ras_ptr),
        ras_cnt:      (MaxRasPtrBits + 1)'(ras_cnt),
        chose_global: chooser[l_idx][1]
    };

    // A mispredict rewinds the RAS pointer and replays the resolved op, overriding IF.
    always_comb begin
        ras_restore = upd_valid && upd_mispredict;
        if (ras_restore) begin
            ras_push = up.call;
            ras_pop  = up.ret;
            ras_addr = upd_pc + 32'd4;
        end else begin
            ras_push = lookup_valid && lookup_advance && lk.call;
            ras_pop  = lookup_valid && lookup_advance && lk.ret;
            ras_addr = lookup_pc + 32'd4;
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PTR_BITS  (PtrBits)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push        (ras_push),
        .pop         (ras_pop),
        .push_addr   (ras_addr),
        .restore     (ras_restore),
        .restore_ptr (upd_meta.ras_ptr[PtrBits-1:0]),
        .restore_cnt (upd_meta.ras_cnt[PtrBits:0]),
        .top         (ras_top),
        .ptr         (ras_ptr),
        .cnt         (ras_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Entries; i++) begin
                local_pht[i]  <= PredWnt;
                global_pht[i] <= PredWnt;
                chooser[i]    <= PredWnt;
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
            ghr_q <= '0;
        end else if (upd_valid) begin
            if (up.branch) begin
                local_pht[u_idx]   <= sat_step(upd_meta.local_st, upd_taken);
                global_pht[u_gidx] <= sat_step(upd_meta.global_st, upd_taken);
                ghr_q              <= {ghr_q[GHR_BITS-2:0], upd_taken};
                if (upd_meta.local_st[1] != upd_meta.global_st[1]) begin
                    chooser[u_idx] <= sat_step(chooser[u_idx],
                                               upd_meta.global_st[1] == upd_taken);
                end
            end
            if (upd_taken) begin
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= upd_pc[31:INDEX_BITS+2];
                btb_target[u_idx] <= upd_target;
            end
        end
    end

    assign unused_meta = ^{upd_meta.ghr, upd_meta.ras_ptr, upd_meta.ras_cnt,
                           upd_meta.chose_global};

endmodule
